// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_ctrl codes, ALUOp/funct encodings, op decode
// and the execute-stage output-buffer occupancy type.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       trap_cap;
    logic       illegal;
  } dec_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  function automatic dec_t alu_decode(input logic [1:0] op, input logic [5:0] fn);
    dec_t d;
    d.ctrl     = CTRL_ADD;
    d.trap_cap = 1'b0;
    d.illegal  = 1'b0;
    case (op)
      ALUOP_ADD: d.ctrl = CTRL_ADD;
      ALUOP_SUB: d.ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (fn)
          FUNCT_ADD:  begin d.ctrl = CTRL_ADD; d.trap_cap = 1'b1; end
          FUNCT_ADDU: d.ctrl = CTRL_ADD;
          FUNCT_SUB:  begin d.ctrl = CTRL_SUB; d.trap_cap = 1'b1; end
          FUNCT_SUBU: d.ctrl = CTRL_SUB;
          FUNCT_AND:  d.ctrl = CTRL_AND;
          FUNCT_OR:   d.ctrl = CTRL_OR;
          FUNCT_NOR:  d.ctrl = CTRL_NOR;
          FUNCT_SLT:  d.ctrl = CTRL_SLT;
          default:    d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_32.sv
// 32-bit combinational ALU: and/or/add/sub/slt/nor with zero, signed
// overflow (add/sub only) and carry-out.
module alu_32
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_ctrl,
  output logic [31:0] res,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    res       = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (alu_ctrl)
      CTRL_AND: res = a & b;
      CTRL_OR:  res = a | b;
      CTRL_NOR: res = ~(a | b);
      CTRL_SLT: res = {31'd0, $signed(a) < $signed(b)};
      CTRL_ADD: begin
        res       = sum[31:0];
        carry_out = sum[32];
        overflow  = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      CTRL_SUB: begin
        res       = diff[31:0];
        carry_out = diff[32];
        overflow  = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      default: res = '0;
    endcase
  end

  assign zero = (res == 32'd0);

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: decodes ALUOp/funct, drives alu_32 and queues results in a
// 2-entry in-order buffer. Define ALU_EX_STAGE_STATS_EN to add pop/trap counters.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [RW-1:0] rd,
  input  logic          is_branch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [RW-1:0] out_rd,
  output logic          out_wr_en,
  output logic          out_trap,
  output logic          out_illegal,
  output logic          out_br_taken,
  output buf_state_t    dbg_state
`ifdef ALU_EX_STAGE_STATS_EN
  ,
  output logic [31:0]   stat_ops,
  output logic [15:0]   stat_traps
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side; producers hold payload while valid && !ready, consumers see a stable head.

  typedef struct packed {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          wr_en;
    logic          trap;
    logic          illegal;
    logic          br_taken;
  } entry_t;

  dec_t          dec;
  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic          alu_ovf;
  logic          carry_unused;
  entry_t        new_entry;
  entry_t        head_q;
  entry_t        tail_q;
  buf_state_t    state_q;
  buf_state_t    state_d;
  logic          in_ready_q;
  logic          push;
  logic          pop;

  assign dec = alu_decode(alu_op, funct);

  alu_32 u_alu (
    .a         (a),
    .b         (b),
    .alu_ctrl  (dec.ctrl),
    .res       (alu_res),
    .zero      (alu_zero),
    .overflow  (alu_ovf),
    .carry_out (carry_unused)
  );

  // Illegal ops report nothing but the illegal flag; a trap keeps the wrapped result.
  always_comb begin
    new_entry          = '0;
    new_entry.rd       = rd;
    if (dec.illegal) begin
      new_entry.illegal = 1'b1;
    end else begin
      new_entry.res      = alu_res;
      new_entry.trap     = dec.trap_cap && alu_ovf;
      new_entry.wr_en    = !is_branch && !(dec.trap_cap && alu_ovf);
      new_entry.br_taken = is_branch && alu_zero;
    end
  end

  assign out_valid = (state_q != BUF_EMPTY);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (pop && !push) state_d = BUF_EMPTY;
      end
      BUF_FULL: if (pop) state_d = BUF_ONE;
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
      case (state_q)
        BUF_EMPTY: if (push) head_q <= new_entry;
        BUF_ONE: begin
          if (push && pop) head_q <= new_entry;
          else if (push)   tail_q <= new_entry;
        end
        BUF_FULL: if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  assign out_res      = head_q.res;
  assign out_rd       = head_q.rd;
  assign out_wr_en    = head_q.wr_en;
  assign out_trap     = head_q.trap;
  assign out_illegal  = head_q.illegal;
  assign out_br_taken = head_q.br_taken;

`ifdef ALU_EX_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_traps <= '0;
    end else if (pop) begin
      stat_ops <= stat_ops + 32'd1;
      if (head_q.trap) stat_traps <= stat_traps + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed-vector bench for alu_ex_stage with an expected-queue scoreboard.
module tb_alu_ex_stage;
  import alu_pkg::*;

  localparam int EW = 41;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  rd;
  logic        is_branch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_trap;
  logic        out_illegal;
  logic        out_br_taken;
  buf_state_t  dbg_state;
`ifdef ALU_EX_STAGE_STATS_EN
  logic [31:0] stat_ops;
  logic [15:0] stat_traps;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act;
  logic [EW-1:0] mon_exp;

  alu_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .funct        (funct),
    .a            (a),
    .b            (b),
    .rd           (rd),
    .is_branch    (is_branch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_rd       (out_rd),
    .out_wr_en    (out_wr_en),
    .out_trap     (out_trap),
    .out_illegal  (out_illegal),
    .out_br_taken (out_br_taken),
    .dbg_state    (dbg_state)
`ifdef ALU_EX_STAGE_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_traps   (stat_traps)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [EW-1:0] mk(input logic [31:0] r, input logic [4:0] d,
                                       input logic wr, input logic tr,
                                       input logic il, input logic bt);
    return {r, d, wr, tr, il, bt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake seen at the falling edge pops at the next rise
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_act = {out_res, out_rd, out_wr_en, out_trap, out_illegal, out_br_taken};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0h expected nothing", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL result rd=%0d: got %0h expected %0h", out_rd, mon_act, mon_exp);
        end
      end
    end
  end

  // Driver
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av,
                      input logic [31:0] bv, input logic [4:0] r, input logic br,
                      input logic [EW-1:0] e);
    bit acc = 1'b0;
    int n = 0;
    alu_op = op; funct = fn; a = av; b = bv; rd = r; is_branch = br;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back(e);
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout rd=%0d: got no accept expected accept", r);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  int c0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0;
    rd = '0; is_branch = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_payload", 64'({out_res, out_rd, out_wr_en, out_trap, out_illegal, out_br_taken}), 64'd0);
    rst = 1'b0;

    // Main function and boundaries, out_ready held high
    send(2'b10, 6'h20, 32'd7,        32'd5,        5'd3,  1'b0, mk(32'd12,         5'd3,  1, 0, 0, 0));
    send(2'b10, 6'h20, 32'h7FFFFFFF, 32'd1,        5'd4,  1'b0, mk(32'h80000000,   5'd4,  0, 1, 0, 0));
    send(2'b10, 6'h21, 32'h7FFFFFFF, 32'd1,        5'd5,  1'b0, mk(32'h80000000,   5'd5,  1, 0, 0, 0));
    send(2'b10, 6'h22, 32'h80000000, 32'd1,        5'd6,  1'b0, mk(32'h7FFFFFFF,   5'd6,  0, 1, 0, 0));
    send(2'b10, 6'h23, 32'h80000000, 32'd1,        5'd7,  1'b0, mk(32'h7FFFFFFF,   5'd7,  1, 0, 0, 0));
    send(2'b00, 6'h00, 32'h7FFFFFFF, 32'd1,        5'd8,  1'b0, mk(32'h80000000,   5'd8,  1, 0, 0, 0));
    send(2'b01, 6'h00, -32'sd50,     -32'sd50,     5'd9,  1'b1, mk(32'd0,          5'd9,  0, 0, 0, 1));
    send(2'b01, 6'h00, 32'd5,        32'd3,        5'd10, 1'b1, mk(32'd2,          5'd10, 0, 0, 0, 0));
    send(2'b10, 6'h2A, -32'sd14,     -32'sd12,     5'd11, 1'b0, mk(32'd1,          5'd11, 1, 0, 0, 0));
    send(2'b10, 6'h2A, -32'sd12,     -32'sd14,     5'd12, 1'b0, mk(32'd0,          5'd12, 1, 0, 0, 0));
    send(2'b10, 6'h00, 32'd3,        32'd4,        5'd13, 1'b0, mk(32'd0,          5'd13, 0, 0, 1, 0));
    send(2'b11, 6'h20, 32'd4,        32'd4,        5'd14, 1'b1, mk(32'd0,          5'd14, 0, 0, 1, 0));
    drain();

    // Throughput: four ops in four cycles
    c0 = cyc;
    send(2'b10, 6'h20, 32'd1,  32'd1,  5'd1, 1'b0, mk(32'd2,          5'd1, 1, 0, 0, 0));
    send(2'b10, 6'h25, 32'hF0, 32'h0F, 5'd2, 1'b0, mk(32'hFF,         5'd2, 1, 0, 0, 0));
    send(2'b10, 6'h22, 32'd10, 32'd3,  5'd3, 1'b0, mk(32'd7,          5'd3, 1, 0, 0, 0));
    send(2'b10, 6'h27, 32'd0,  32'd0,  5'd4, 1'b0, mk(32'hFFFFFFFF,   5'd4, 1, 0, 0, 0));
    check("throughput_cycles", 64'(cyc - c0), 64'd4);
    drain();

    // Backpressure: third op stalls until the consumer drains
    out_ready = 1'b0;
    send(2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd1, 1'b0, mk(32'h00F000F0, 5'd1, 1, 0, 0, 0));
    send(2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd2, 1'b0, mk(32'hFFF0FFF0, 5'd2, 1, 0, 0, 0));
    check("full_in_ready", 64'(in_ready), 64'd0);
    fork
      send(2'b10, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b0, mk(32'h000F000F, 5'd3, 1, 0, 0, 0));
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_head", 64'({out_valid, out_res}), 64'({1'b1, 32'h00F000F0}));
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef ALU_EX_STAGE_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'd19);
    check("stat_traps", 64'(stat_traps), 64'd2);
`endif

    // Reset while FULL, with an op offered during the reset cycle
    out_ready = 1'b0;
    send(2'b10, 6'h20, 32'd100, 32'd1, 5'd20, 1'b0, mk(32'd101, 5'd20, 1, 0, 0, 0));
    send(2'b10, 6'h20, 32'd200, 32'd1, 5'd21, 1'b0, mk(32'd201, 5'd21, 1, 0, 0, 0));
    rst = 1'b1;
    exp_q.delete();
    alu_op = 2'b10; funct = 6'h20; a = 32'd50; b = 32'd50; rd = 5'd30; is_branch = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_payload", 64'({out_res, out_rd, out_wr_en, out_trap, out_illegal, out_br_taken}), 64'd0);
`ifdef ALU_EX_STAGE_STATS_EN
    check("midrst_stats", 64'({stat_ops, stat_traps}), 64'd0);
`endif
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);
    send(2'b10, 6'h20, 32'd1, 32'd2, 5'd22, 1'b0, mk(32'd3, 5'd22, 1, 0, 0, 0));
    drain();
`ifdef ALU_EX_STAGE_STATS_EN
    check("post_rst_stats", 64'({stat_ops, stat_traps}), 64'({32'd1, 16'd0}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- MIPS execute stage wrapped around the existing 32-bit ALU (alu_32).
- Decodes ALUOp/funct into the 4-bit alu_ctrl code and drives alu_32.
- Registers results into a 2-entry in-order output buffer with valid/ready handshakes on both sides.
- Flags signed-overflow traps, illegal functs and branch-taken, and passes the write-back tag downstream to the MEM/WB stage.

Parameters:
- DW, 32, datapath width (fixed by alu_32; only 32 is supported).
- RW, 5, register-tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op; registered.
- alu_op  in  2  00 = add, 01 = sub (beq), 10 = R-type use funct, 11 = illegal.
- funct  in  6  R-type function field.
- a  in  DW  operand A.
- b  in  DW  operand B.
- rd  in  RW  destination tag.
- is_branch  in  1  beq op.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  downstream accepts head.
- out_res  out  DW  ALU result.
- out_rd  out  RW  destination tag.
- out_wr_en  out  1  write-back permitted.
- out_trap  out  1  signed-overflow trap.
- out_illegal  out  1  unsupported op.
- out_br_taken  out  1  is_branch and zero.

Behaviour:
- Decode when alu_op = 10, by funct:
  - 100000 add -> 0010, trap-capable.
  - 100001 addu -> 0010, never traps.
  - 100010 sub -> 0110, trap-capable.
  - 100011 subu -> 0110, never traps.
  - 100100 -> 0000 (and).
  - 100101 -> 0001 (or).
  - 100111 -> 1100 (nor).
  - 101010 -> 0111 (slt).
  - Any other funct is illegal.
- Decode for other alu_op values: 00 -> 0010, no trap. 01 -> 0110, no trap. 11 -> illegal.
- alu_32 is combinational on a, b and the decoded code. Its carry_out is ignored.
- Accept: in_valid && in_ready at a rising edge writes {res, rd, flags} to the buffer tail.
- Latency: out_valid rises on the edge after the accept.
- Pop: out_valid && out_ready removes the head at that edge.
- Buffer is 2 entries with occupancy states EMPTY, ONE, FULL:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL. Pop only -> EMPTY. Push and pop together -> ONE.
  - FULL: pop -> ONE. No push is possible.
- in_ready is registered and equals (next state != FULL).
- With out_ready held at 1, throughput is one op per cycle.
- Order is strictly FIFO. Head outputs stay stable while out_valid && !out_ready.
- Trap: a trap-capable op with alu overflow = 1 sets out_trap = 1 and out_wr_en = 0. out_res still carries the wrapped sum.
- Illegal: out_illegal = 1, out_res = 0, out_wr_en = 0, out_trap = 0, out_br_taken = 0.
- Otherwise out_wr_en = !is_branch.
- out_br_taken = is_branch && (alu_res == 0), valid only for legal ops.
- Reset (synchronous, including mid-operation):
  - Buffer goes to EMPTY and all entries are discarded.
  - out_valid = 0, in_ready = 1.
  - out_res, out_rd, out_wr_en, out_trap, out_illegal, out_br_taken = 0.
  - An in_valid asserted during the reset cycle is not accepted.
- Outputs while out_valid = 0 hold their last value. They are don't-care for consumers.

Optional Feature:
- Macro: ALU_EX_STAGE_STATS_EN.
- With the macro defined:
  - Adds out ports stat_ops [31:0] and stat_traps [15:0].
  - stat_ops counts pops. stat_traps counts pops with out_trap = 1.
  - Both counters wrap modulo 2^width and clear on rst.
- Without it: neither port nor counter logic exists. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - The alu_ctrl localparams: AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, SUB = 4'b0110, SLT = 4'b0111, NOR = 4'b1100.
  - The ALUOp encodings and funct constants.
  - A decode function returning {ctrl, trap_cap, illegal}.
- Sub-module: the existing alu_32 is instantiated unchanged.
- The buffer stays inline; no further sub-module is needed.

Test Plan:
- Basic add: alu_op = 10, funct = 100000, a = 7, b = 5, out_ready = 1 -> next cycle out_valid = 1, out_res = 12, out_wr_en = 1, out_trap = 0.
- Overflow, signed vs unsigned:
  - add 0x7FFFFFFF + 1 -> out_res = 0x80000000, out_trap = 1, out_wr_en = 0.
  - The same operands via addu -> out_trap = 0, out_wr_en = 1.
- Branch and slt:
  - beq (alu_op = 01, is_branch = 1) a = b = -50 -> out_res = 0, out_br_taken = 1, out_wr_en = 0.
  - slt a = -14, b = -12 -> out_res = 1.
- Backpressure: out_ready = 0, three back-to-back ops (and, or, nor on 0xF0F0F0F0 / 0x0FF00FF0):
  - in_ready = 0 after the 2nd accept and the 3rd op is held.
  - out_ready = 1 -> results 0x00F000F0, 0xFFF0FFF0, 0x000F000F in order.
- Illegal op: funct = 000000 -> out_illegal = 1, out_res = 0, out_wr_en = 0.
  - alu_op = 11 gives the same response.
- Reset mid-operation: buffer FULL, assert rst one cycle -> out_valid = 0, in_ready = 1 next cycle.
  - Stale results never appear afterwards.
  - With ALU_EX_STAGE_STATS_EN defined, both counters read 0.
